// File: rtl/tcp_rx_cmd_decoder.sv
// SiTCP TCP receive path: elastic byte FIFO feeding a framed register-write parser that commits only checksum-verified payloads.
// Optional inter-byte timeout is compiled in with `define RX_TIMEOUT_EN.
module tcp_rx_cmd_decoder #(
    parameter int         FIFO_AW     = 5,
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_wr,
    input  logic [7:0]  rx_data,
    output logic [15:0] rx_wc,
    output logic        reg_we,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wd,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        ovf
);
    localparam int         DEPTH = 1 << FIFO_AW;
    localparam int         LW    = $clog2(MAX_LEN + 1);
    localparam int         IW    = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT} state_t;
    state_t r_state, w_next;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_cnt;
    logic               r_ovf;
    logic               w_full, w_empty, w_push, w_pop;
    logic [7:0]         w_byte;

    logic [7:0]    r_addr, r_chk;
    logic [LW-1:0] r_len;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_stage [MAX_LEN];
    logic          w_last, w_chk_ok, w_tmo;
    logic          w_we, w_ok, w_err;
    logic [7:0]    w_wa, w_wd;
    logic          r_we, r_ok, r_err;
    logic [7:0]    r_wa, r_wd, r_err_cnt;

    assign w_full   = (r_cnt == (FIFO_AW + 1)'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_push   = rx_wr && !w_full;
    assign w_pop    = !w_empty && (r_state != S_COMMIT);
    assign w_byte   = r_mem[r_rptr];
    assign w_chk_ok = (w_byte == r_chk);
    assign w_last   = (LW'(r_idx) == r_len - 1'b1);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
            if (rx_wr && w_full) r_ovf <= 1'b1;
        end
    end

`ifdef RX_TIMEOUT_EN
    // Counts only stalled mid-frame cycles; any pop leaves the FIFO non-empty state and clears it.
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_idle;
    logic          w_wait;
    assign w_wait = (r_state inside {S_ADDR, S_LEN, S_DATA, S_CHK}) && w_empty;
    assign w_tmo  = w_wait && (r_idle == TW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_idle <= '0;
        else if (!w_wait || w_tmo) r_idle <= '0;
        else                      r_idle <= r_idle + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_pop && w_byte == SOF_BYTE) w_next = S_ADDR;
            S_ADDR:   if (w_pop) w_next = S_LEN;
            S_LEN:    if (w_pop) w_next = (w_byte > MAX_B) ? S_IDLE : ((w_byte == 8'h00) ? S_CHK : S_DATA);
            S_DATA:   if (w_pop && w_last) w_next = S_CHK;
            // A single-byte payload is written straight from CHK, so COMMIT only sees len >= 2.
            S_CHK:    if (w_pop) w_next = (w_chk_ok && r_len > LW'(1)) ? S_COMMIT : S_IDLE;
            S_COMMIT: if (w_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_tmo) w_next = S_IDLE;
    end

    always_comb begin
        w_we  = 1'b0;
        w_ok  = 1'b0;
        w_err = 1'b0;
        w_wa  = r_wa;
        w_wd  = r_wd;
        case (r_state)
            S_LEN: if (w_pop && w_byte > MAX_B) w_err = 1'b1;
            S_CHK: begin
                if (w_pop) begin
                    if (!w_chk_ok) begin
                        w_err = 1'b1;
                    end else if (r_len == '0) begin
                        w_ok = 1'b1;
                    end else begin
                        w_we = 1'b1;
                        w_wa = r_addr;
                        w_wd = r_stage[0];
                        w_ok = (r_len == LW'(1));
                    end
                end
            end
            S_COMMIT: begin
                w_we = 1'b1;
                w_wa = r_addr + 8'(r_idx);
                w_wd = r_stage[r_idx];
                w_ok = w_last;
            end
            default: ;
        endcase
        if (w_tmo) w_err = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_chk  <= '0;
        end else begin
            case (r_state)
                S_ADDR: if (w_pop) begin
                    r_addr <= w_byte;
                    r_chk  <= w_byte;
                end
                S_LEN: if (w_pop) begin
                    r_chk <= r_chk ^ w_byte;
                    r_len <= LW'(w_byte);
                    r_idx <= '0;
                end
                S_DATA: if (w_pop) begin
                    r_chk <= r_chk ^ w_byte;
                    r_idx <= r_idx + 1'b1;
                end
                S_CHK:    if (w_pop) r_idx <= IW'(1);
                S_COMMIT: r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_DATA && w_pop) r_stage[r_idx] <= w_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_wa      <= '0;
            r_wd      <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_we  <= w_we;
            r_wa  <= w_wa;
            r_wd  <= w_wd;
            r_ok  <= w_ok;
            r_err <= w_err;
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign rx_wc     = {{(15 - FIFO_AW){1'b1}}, r_cnt};
    assign reg_we    = r_we;
    assign reg_addr  = r_wa;
    assign reg_wd    = r_wd;
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
    assign err_cnt   = r_err_cnt;
    assign ovf       = r_ovf;
endmodule

// File: doc/tcp_rx_cmd_decoder.md
Name: tcp_rx_cmd_decoder

Overview:
- Receive-side counterpart of the TCP transmit data path. Consumes the SiTCP TCP receive byte stream (write strobe and data) into a small elastic FIFO.
- Reports FIFO occupancy back to SiTCP in TCP_RX_WC format.
- Parses framed register-write commands. Payload is committed to a user register bus only after the checksum is verified.
- Sits in the 200 MHz system domain beside the LED/RBCP logic; reset is driven from the inverted TCP open-acknowledge.

Parameters:
- FIFO_AW, 5, log2 of the input FIFO depth (32 bytes).
- MAX_LEN, 16, maximum payload bytes per frame; also the staging buffer depth.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYC, 200000, inter-byte timeout in clk cycles (1 ms at 200 MHz). Used only with the optional feature.

Ports:
- clk  in  1  system clock (CLK_200M)
- rst  in  1  asynchronous active-high reset
- rx_wr  in  1  byte write strobe from SiTCP TCP_RX_WR
- rx_data  in  8  byte from SiTCP TCP_RX_DATA
- rx_wc  out  16  to SiTCP TCP_RX_WC: {ones in bits 15:FIFO_AW+1, occupancy[FIFO_AW:0]}
- reg_we  out  1  register write strobe, one cycle per byte
- reg_addr  out  8  register address
- reg_wd  out  8  register write data
- frame_ok  out  1  one-cycle pulse: frame accepted and fully written
- frame_err  out  1  one-cycle pulse: frame discarded
- err_cnt  out  8  discarded-frame count, saturates at 8'hFF
- ovf  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset values:
  - All outputs are 0, except rx_wc, which is {ones, 0}.
  - FIFO is emptied; state is IDLE; checksum is cleared.
  - Reset mid-frame abandons the frame; no reg_we is issued afterwards.
- Input FIFO:
  - A byte is pushed on rx_wr when not full. rx_wr while full drops the byte and sets ovf.
  - Occupancy is registered and updates the cycle after a push or pop. Simultaneous push and pop leaves the count unchanged.
  - Full is occupancy == 2^FIFO_AW. Pointers wrap modulo the depth.
- Parser pops one byte per cycle whenever the FIFO is non-empty and the state is not COMMIT.
- Frame format: SOF, ADDR, LEN, DATA[0..LEN-1], CHK. CHK is the 8-bit XOR of ADDR, LEN and all DATA bytes. LEN = 0 is legal (no writes).
- States:
  - IDLE: byte == SOF_BYTE -> ADDR. Any other byte is discarded silently (resync hunt; no error).
  - ADDR: latch addr; chk = byte; -> LEN.
  - LEN:
    - byte > MAX_LEN -> frame_err, err_cnt++, go to IDLE.
    - byte == 0 -> CHK.
    - otherwise latch len and go to DATA.
    - chk ^= byte in every case.
  - DATA: write byte to staging[idx]; chk ^= byte; idx++. When idx reaches len-1 -> CHK.
  - CHK:
    - byte == chk, len > 0 -> COMMIT.
    - byte == chk, len == 0 -> frame_ok pulse, IDLE.
    - mismatch -> frame_err, err_cnt++, IDLE.
  - COMMIT:
    - One write per cycle, i = 0..len-1: reg_we = 1, reg_addr = addr + i (mod 256, wraps 8'hFF -> 8'h00), reg_wd = staging[i].
    - frame_ok asserts coincident with the last reg_we, then -> IDLE.
    - No pops occur during COMMIT; the FIFO keeps accepting pushes.
- Outputs are registered. The first reg_we appears 1 cycle after the CHK byte is popped.
- frame_ok and frame_err are never high in the same cycle.
- err_cnt increments at most once per frame.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while the state is ADDR, LEN, DATA or CHK and the FIFO is empty; it clears on any pop.
  - At TIMEOUT_CYC the counter aborts the frame: frame_err, err_cnt++, -> IDLE, with staged data discarded.
- Undefined:
  - No counter logic is present; the parser waits indefinitely mid-frame.

Test Plan:
- Good frame: push A5 10 02 11 22 21 on consecutive cycles. Required: reg_we on two consecutive cycles, (10,11) then (11,22); frame_ok with the second write; err_cnt = 0.
- Bad checksum: push A5 10 02 11 22 20. Required: no reg_we; one frame_err; err_cnt = 1.
- Garbage, oversize and zero-length frames:
  - Push 00 FF then A5 FE 01 77 88; the 00 FF are discarded silently.
  - 88 = FE^01^77, so exactly one write occurs at reg_addr FE. No error is counted.
  - Push A5 00 11 11: the LEN > MAX_LEN error is counted once.
  - Push A5 40 00 40: frame_ok with no reg_we.
- Address wrap and full length: ADDR = FF, LEN = 16, with valid CHK. Required: writes at FF, 00 .. 0E in order.
- FIFO back-pressure: push 40 bytes back-to-back during a COMMIT of 16 bytes. Required:
  - rx_wc shows bits 15:6 set with the occupancy count.
  - ovf sets only if occupancy reaches 32 with rx_wr high.
  - Stored bytes are parsed correctly afterwards.
- Reset and timeout:
  - Assert rst after A5 10 03 11. Required: no writes and all outputs at reset values.
  - With RX_TIMEOUT_EN and TIMEOUT_CYC = 100, push A5 10 then stall 100 cycles. Required: frame_err, err_cnt = 1, and a following good frame is accepted.
